// File: rtl/sym_pkg.sv
// Shared sym datapath geometry: four 8-bit lanes packed into a 32-bit word.
// Lane helpers are used by the sym datapath, the arbiter and the benches alike.
package sym_pkg;
    localparam int SYM_W  = 32;
    localparam int LANE_W = 8;
    localparam int LANES  = SYM_W / LANE_W;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [SYM_W-1:0]  sym_word_t;

    function automatic lane_t lane_get(input sym_word_t v, input int unsigned k);
        return v[k*LANE_W +: LANE_W];
    endfunction

    // Lane 3 is the most significant byte.
    function automatic sym_word_t lane_pack(input lane_t l3, input lane_t l2,
                                            input lane_t l1, input lane_t l0);
        return {l3, l2, l1, l0};
    endfunction
endpackage

// File: rtl/sym_rsp_fifo.sv
// Response FIFO: first-word fall-through circular buffer, one push and one pop per cycle.
// Latency: push visible at head next cycle; no overflow check, the writer holds the credit.
module sym_rsp_fifo #(
    parameter int DW    = 34,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_vld_i,
    input  logic [DW-1:0]          push_dat_i,
    input  logic                   pop_rdy_i,
    output logic                   pop_vld_o,
    output logic [DW-1:0]          pop_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_pop;

    assign pop_vld_o = (count_q != '0);
    assign do_pop    = pop_vld_o && pop_rdy_i;
    // Head is forced to zero when empty so stale entries never leak out.
    assign pop_dat_o = pop_vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_vld_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(push_vld_i) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld_i) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

// File: rtl/sym_arbiter.sv
// Round-robin share of one sym datapath between NREQ requesters, results tagged by id.
// Latency: handshake to rsp_valid is LAT+2 cycles; grants stall when en=0 or credits run out.
module sym_arbiter
    import sym_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int W         = SYM_W,
    parameter int LAT       = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    input  logic [NREQ*W-1:0]        req_c,
    input  logic [NREQ*W-1:0]        req_i,
    output logic [W-1:0]             sym_a,
    output logic [W-1:0]             sym_b,
    output logic [W-1:0]             sym_c,
    output logic [W-1:0]             sym_i,
    input  logic [W-1:0]             sym_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [W-1:0]             rsp_data,
    output logic                     busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(RSP_DEPTH + LAT + 2) + 1;

    logic [IDW-1:0]          ptr_q, ptr_d, win_id, cand;
    logic                    win_found, credit_ok, hs;
    logic [W-1:0]            sym_a_q, sym_b_q, sym_c_q, sym_i_q;
    logic [LAT:0]            tag_vld_q;
    logic [IDW-1:0]          tag_id_q [LAT+1];
    logic [$clog2(RSP_DEPTH):0] fifo_count;
    logic [CW-1:0]           inflight;

    // Pops in the current cycle are deliberately not credited back until the next cycle.
    always_comb begin
        inflight = CW'(fifo_count);
        for (int s = 0; s <= LAT; s++) inflight = inflight + CW'(tag_vld_q[s]);
    end
    assign credit_ok = en && (inflight < CW'(RSP_DEPTH));

    always_comb begin
        win_found = 1'b0;
        win_id    = ptr_q;
        cand      = '0;
        for (int o = 0; o < NREQ; o++) begin
            cand = IDW'((int'(ptr_q) + o) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign hs        = win_found && credit_ok && rst_n;
    assign req_ready = hs ? (NREQ'(1) << win_id) : '0;
    assign ptr_d     = !hs ? ptr_q : ((win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            sym_a_q   <= '0;
            sym_b_q   <= '0;
            sym_c_q   <= '0;
            sym_i_q   <= '0;
            tag_vld_q <= '0;
            for (int s = 0; s <= LAT; s++) tag_id_q[s] <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (hs) begin
                sym_a_q <= req_a[win_id*W +: W];
                sym_b_q <= req_b[win_id*W +: W];
                sym_c_q <= req_c[win_id*W +: W];
                sym_i_q <= req_i[win_id*W +: W];
            end
            // Stage s holds the tag whose operands entered sym s cycles ago.
            tag_vld_q[0] <= hs;
            tag_id_q[0]  <= win_id;
            for (int s = 1; s <= LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

    assign sym_a = sym_a_q;
    assign sym_b = sym_b_q;
    assign sym_c = sym_c_q;
    assign sym_i = sym_i_q;

    sym_rsp_fifo #(
        .DW    (IDW + W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_vld_i (tag_vld_q[LAT]),
        .push_dat_i ({tag_id_q[LAT], sym_cout}),
        .pop_rdy_i  (rsp_ready),
        .pop_vld_o  (rsp_valid),
        .pop_dat_o  ({rsp_id, rsp_data}),
        .count_o    (fifo_count)
    );

    assign busy = (|tag_vld_q) || (fifo_count != '0);
endmodule

// File: tb/tb_sym_arbiter.sv
// Bench for sym_arbiter: a one-cycle sym stand-in feeds sym_cout; a queue-based model
// predicts grants, responses and busy every cycle, plus table rows and directed corners.
module tb_sym_arbiter;
    import sym_pkg::*;

    localparam int NREQ = 4, W = 32, LAT = 1, RSP_DEPTH = 4;
    localparam int IDW = $clog2(NREQ);

    logic              clk = 1'b0, rst_n = 1'b1, en = 1'b0;
    logic [NREQ-1:0]   req_valid = '0, req_ready;
    logic [NREQ*W-1:0] req_a = '0, req_b = '0, req_c = '0, req_i = '0;
    logic [W-1:0]      sym_a, sym_b, sym_c, sym_i, sym_cout;
    logic              rsp_valid, rsp_ready = 1'b0, busy;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;

    always #5 clk = ~clk;

    sym_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_i(req_i),
        .sym_a(sym_a), .sym_b(sym_b), .sym_c(sym_c), .sym_i(sym_i),
        .sym_cout(sym_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    // Per lane: I bit0 set -> a*b+c, clear -> a+b-c (all mod 256).
    function automatic logic [W-1:0] sym_fn(input logic [W-1:0] a, b, c, i);
        logic [W-1:0] r;
        lane_t la, lb, lc, li, t;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            la = lane_get(a, k); lb = lane_get(b, k);
            lc = lane_get(c, k); li = lane_get(i, k);
            t = li[0] ? (la * lb + lc) : (la + lb - lc);
            r[k*LANE_W +: LANE_W] = t;
        end
        return r;
    endfunction

    always_ff @(posedge clk) sym_cout <= sym_fn(sym_a, sym_b, sym_c, sym_i);

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           avail;
    } rsp_t;

    typedef struct {
        bit              en;
        bit              rr;
        logic [NREQ-1:0] vld;
        logic [NREQ-1:0] exp;
    } row_t;

    rsp_t         sb[$];
    row_t         tbl[17];
    int           ptr_m = 0, cyc = 0, checks = 0, errors = 0;
    logic [W-1:0] va[NREQ], vb[NREQ], vc[NREQ], vi[NREQ];
    logic [W-1:0] exp_sa = '0, exp_sb = '0, exp_sc = '0, exp_si = '0;
    int           w_d;
    logic [NREQ-1:0] r_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic new_ops(input int k);
        va[k] = $urandom; vb[k] = $urandom; vc[k] = $urandom; vi[k] = $urandom;
    endtask

    task automatic model_reset();
        sb.delete();
        ptr_m = 0;
        exp_sa = '0; exp_sb = '0; exp_sc = '0; exp_si = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_sym_a"}, sym_a, 0);
        check({tag, "_sym_b"}, sym_b, 0);
        check({tag, "_sym_c"}, sym_c, 0);
        check({tag, "_sym_i"}, sym_i, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // One cycle: entered at posedge+1 with control inputs set; leaves at next posedge+1.
    task automatic step(output int win, output logic [NREQ-1:0] act_rdy);
        logic [NREQ-1:0] exp_rdy;
        bit pop;
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*W +: W] = va[k]; req_b[k*W +: W] = vb[k];
            req_c[k*W +: W] = vc[k]; req_i[k*W +: W] = vi[k];
        end
        #1;
        exp_rdy = '0;
        win = -1;
        if (en && sb.size() < RSP_DEPTH)
            for (int o = 0; o < NREQ; o++) begin
                int k;
                k = (ptr_m + o) % NREQ;
                if (win < 0 && req_valid[k]) win = k;
            end
        if (win >= 0) exp_rdy[win] = 1'b1;
        act_rdy = req_ready;
        check("req_ready", req_ready, exp_rdy);
        check("busy", busy, sb.size() != 0);
        check("sym_a", sym_a, exp_sa);
        check("sym_b", sym_b, exp_sb);
        check("sym_c", sym_c, exp_sc);
        check("sym_i", sym_i, exp_si);
        pop = 1'b0;
        if (sb.size() > 0 && sb[0].avail <= cyc) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_id", rsp_id, sb[0].id);
            check("rsp_data", rsp_data, sb[0].data);
            pop = rsp_ready;
        end else begin
            check("rsp_valid", rsp_valid, 0);
        end
        if (win >= 0) begin
            sb.push_back('{id: win, data: sym_fn(va[win], vb[win], vc[win], vi[win]),
                           avail: cyc + 2 + LAT});
            ptr_m = (win + 1) % NREQ;
            exp_sa = va[win]; exp_sb = vb[win]; exp_sc = vc[win]; exp_si = vi[win];
            new_ops(win);
        end
        if (pop) void'(sb.pop_front());
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (sb.size() != 0 && n < 20) begin
            step(w_d, r_d);
            n++;
        end
        step(w_d, r_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int lat, acc, n, left;
        int rem[NREQ];

        // Fairness from ptr=0, drain with one en=0 row, then the 3/1 wrap-and-skip pattern.
        for (int i = 0; i < 8; i++) tbl[i] = '{1, 1, 4'hF, 4'b0001 << (i % 4)};
        tbl[8]  = '{1, 1, 4'h0, 4'h0};
        tbl[9]  = '{0, 1, 4'hF, 4'h0};
        tbl[10] = '{1, 1, 4'h0, 4'h0};
        tbl[11] = '{1, 1, 4'h0, 4'h0};
        tbl[12] = '{1, 1, 4'h2, 4'h2};
        tbl[13] = '{1, 1, 4'hA, 4'h8};
        tbl[14] = '{1, 1, 4'hA, 4'h2};
        tbl[15] = '{1, 1, 4'hA, 4'h8};
        tbl[16] = '{1, 1, 4'h0, 4'h0};
        for (int k = 0; k < NREQ; k++) new_ops(k);

        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 17; i++) begin
            en = tbl[i].en; rsp_ready = tbl[i].rr; req_valid = tbl[i].vld;
            step(w_d, r_d);
            check($sformatf("table_row%0d", i), r_d, tbl[i].exp);
        end

        // Single op with fixed operands: exactly LAT+2 cycles to rsp_valid.
        drain();
        en = 1'b1;
        va[0] = lane_pack(8'd1, 8'd1, 8'd3, 8'd4);
        vb[0] = lane_pack(8'd5, 8'd6, 8'd2, 8'd1);
        vc[0] = lane_pack(8'd2, 8'd1, 8'd2, 8'd4);
        vi[0] = lane_pack(8'd1, 8'd0, 8'd0, 8'd1);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        step(w_d, r_d);
        check("single_grant", r_d, 4'b0001);
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            step(w_d, r_d);
            lat++;
        end
        check("single_latency", lat, 3);
        check("single_rsp_id", rsp_id, 0);
        check("single_rsp_data", rsp_data, 32'h07060308);
        step(w_d, r_d);

        // Backpressure: six ops offered, four credits.
        drain();
        en = 1'b1;
        rsp_ready = 1'b0;
        rem = '{2, 2, 1, 1};
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < NREQ; k++) req_valid[k] = (rem[k] > 0);
            step(w_d, r_d);
            for (int k = 0; k < NREQ; k++) if (r_d[k]) begin rem[k]--; acc++; end
        end
        check("bp_accepted", acc, RSP_DEPTH);
        rsp_ready = 1'b1;
        n = 0;
        left = 2;
        while ((left > 0 || sb.size() > 0) && n < 40) begin
            for (int k = 0; k < NREQ; k++) req_valid[k] = (rem[k] > 0);
            step(w_d, r_d);
            for (int k = 0; k < NREQ; k++) if (r_d[k]) rem[k]--;
            left = rem[0] + rem[1] + rem[2] + rem[3];
            n++;
        end
        check("bp_remaining_granted", left, 0);

        // en drops with two ops in flight; both must still drain.
        drain();
        en = 1'b1;
        req_valid = 4'b0100;
        step(w_d, r_d);
        step(w_d, r_d);
        en = 1'b0;
        req_valid = 4'hF;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid && rsp_ready) n++;
            step(w_d, r_d);
        end
        check("en0_rsp_count", n, 2);
        check("en0_busy_end", busy, 0);

        // Reset with two ops in flight: no response may emerge afterwards.
        drain();
        en = 1'b1;
        req_valid = 4'b0011;
        step(w_d, r_d);
        step(w_d, r_d);
        check("midrst_busy_before", busy, 1);
        req_valid = 4'hF;
        rst_n = 1'b0;
        #1 check_zero("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        req_valid = '0;
        for (int c = 0; c < 8; c++) step(w_d, r_d);

        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 7) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_valid = NREQ'($urandom);
            step(w_d, r_d);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
